// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step, breakpoint and read wait-state controller driving the 6502 RDY pin.
// Latency: RDY is registered one CLK after the PHI2 rise it reacts to; buttons take debounce + 3 CLK.
// Backpressure: throttles the CPU only, via RDY low in HALT and WAIT. Writes are never stretched.

// Button conditioner: 2-FF synchronizer, then a stable-level filter that emits one pulse per press.
module cpu_run_ctrl_btn #(
  parameter int CNT = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_evt
);

  localparam int CW = (CNT > 0) ? $clog2(CNT + 1) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic [CW-1:0] r_cnt;
  logic          r_evt;

  // Synchronize, then accept a new level only after it has held for CNT clocks; pulse on the fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1  <= 1'b1;
      r_s2  <= 1'b1;
      r_db  <= 1'b1;
      r_cnt <= '0;
      r_evt <= 1'b0;
    end else begin
      r_s1  <= i_btn_n;
      r_s2  <= r_s1;
      r_evt <= 1'b0;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(CNT)) begin
        r_db  <= r_s2;
        r_cnt <= '0;
        r_evt <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_evt = r_evt;

endmodule

module cpu_run_ctrl #(
  parameter int         SYSCLK_MHZ   = 27,
  parameter int         DEBOUNCE_MS  = 10,
  parameter logic [3:0] WS_REGION    = 4'hA,
  parameter int         WS_CYCLES    = 0,
  parameter bit         START_HALTED = 1'b0
) (
  input  logic        CLK,
  input  logic        RES_,
  input  logic        PHI2,
  input  logic        SYNC,
  input  logic        RW_,
  input  logic [15:0] ABUS,
  input  logic        TRAP,
  input  logic        HALT_BTN_,
  input  logic        STEP_BTN_,
  input  logic        RUN_BTN_,
  input  logic        BP_EN,
  input  logic [15:0] BP_ADDR,
  output logic        RDY,
  output logic        HALTED,
  output logic        BP_HIT,
  output logic [1:0]  STATE
);

  localparam int DB_CNT = SYSCLK_MHZ * 1000 * DEBOUNCE_MS;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam state_t RST_STATE = START_HALTED ? S_HALT : S_RUN;

  state_t     r_state;
  logic       r_rdy;
  logic       r_phi2;
  logic       r_phi2_d;
  logic       r_halt_req;
  logic       r_skip;
  logic       r_ws_done;
  logic       r_bp_hit;
  logic       r_step_seen;
  logic [3:0] r_wcnt;

  state_t     w_nxt;
  logic       w_halt_req_n;
  logic       w_skip_n;
  logic       w_ws_done_n;
  logic       w_bp_hit_n;
  logic       w_step_seen_n;
  logic [3:0] w_wcnt_n;
  logic       w_rdy_n;

  logic       w_ev_halt;
  logic       w_ev_step;
  logic       w_ev_run;
  logic       w_p2r;
  logic       w_p2f;
  logic       w_bp_match;
  logic       w_slow_rd;

  cpu_run_ctrl_btn #(.CNT(DB_CNT)) u_halt_btn (
    .i_clk(CLK), .i_rst_n(RES_), .i_btn_n(HALT_BTN_), .o_evt(w_ev_halt)
  );
  cpu_run_ctrl_btn #(.CNT(DB_CNT)) u_step_btn (
    .i_clk(CLK), .i_rst_n(RES_), .i_btn_n(STEP_BTN_), .o_evt(w_ev_step)
  );
  cpu_run_ctrl_btn #(.CNT(DB_CNT)) u_run_btn (
    .i_clk(CLK), .i_rst_n(RES_), .i_btn_n(RUN_BTN_), .o_evt(w_ev_run)
  );

  // PHI2 edge detection on the registered phase; bus inputs are only trusted on the rise pulse.
  always_ff @(posedge CLK or negedge RES_) begin
    if (!RES_) begin
      r_phi2   <= 1'b0;
      r_phi2_d <= 1'b0;
    end else begin
      r_phi2   <= PHI2;
      r_phi2_d <= r_phi2;
    end
  end

  assign w_p2r      = r_phi2 & ~r_phi2_d;
  assign w_p2f      = ~r_phi2 & r_phi2_d;
  // skip lets the instruction we halted on execute once we resume from it.
  assign w_bp_match = BP_EN && (ABUS == BP_ADDR) && !r_skip;
  assign w_slow_rd  = RW_ && (ABUS[15:12] == WS_REGION) && (WS_CYCLES != 0) && !r_ws_done;

  // State and flag registers; RDY is registered from the next state so it lands one CLK after p2r.
  always_ff @(posedge CLK or negedge RES_) begin
    if (!RES_) begin
      r_state     <= RST_STATE;
      r_rdy       <= ~START_HALTED;
      r_halt_req  <= 1'b0;
      r_skip      <= 1'b0;
      r_ws_done   <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_step_seen <= 1'b0;
      r_wcnt      <= 4'd0;
    end else begin
      r_state     <= w_nxt;
      r_rdy       <= w_rdy_n;
      r_halt_req  <= w_halt_req_n;
      r_skip      <= w_skip_n;
      r_ws_done   <= w_ws_done_n;
      r_bp_hit    <= w_bp_hit_n;
      r_step_seen <= w_step_seen_n;
      r_wcnt      <= w_wcnt_n;
    end
  end

  // Next-state and flag updates; CPU-cycle decisions are taken on p2r, buttons act any time in HALT.
  always_comb begin
    w_nxt         = r_state;
    w_halt_req_n  = r_halt_req | w_ev_halt;
    w_skip_n      = r_skip;
    w_ws_done_n   = r_ws_done;
    w_bp_hit_n    = r_bp_hit;
    w_step_seen_n = r_step_seen;
    w_wcnt_n      = r_wcnt;
    case (r_state)
      S_RUN: begin
        if (w_p2r) begin
          w_skip_n = 1'b0;
          if (TRAP) begin
            w_nxt        = S_HALT;
            w_halt_req_n = 1'b0;
          end else if (SYNC && (r_halt_req || w_bp_match)) begin
            w_nxt        = S_HALT;
            w_halt_req_n = 1'b0;
            w_bp_hit_n   = w_bp_match;
          end else if (w_slow_rd) begin
            w_nxt    = S_WAIT;
            w_wcnt_n = 4'(WS_CYCLES);
          end else begin
            w_ws_done_n = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (w_p2r && TRAP) begin
          w_nxt        = S_HALT;
          w_halt_req_n = 1'b0;
          w_wcnt_n     = 4'd0;
        end else if (r_wcnt == 4'd0) begin
          // The repeated access completes with RDY high; ws_done stops it re-entering WAIT.
          w_nxt       = S_RUN;
          w_ws_done_n = 1'b1;
        end else if (w_p2f) begin
          w_wcnt_n = r_wcnt - 4'd1;
        end
      end
      S_STEP: begin
        if (w_p2r) begin
          w_skip_n = 1'b0;
          if (TRAP) begin
            w_nxt        = S_HALT;
            w_halt_req_n = 1'b0;
          end else if (SYNC) begin
            // First fetch seen is the held one; the next fetch belongs to the following instruction.
            if (r_step_seen) begin
              w_nxt        = S_HALT;
              w_halt_req_n = 1'b0;
            end else begin
              w_step_seen_n = 1'b1;
            end
          end
        end
      end
      S_HALT: begin
        w_halt_req_n = 1'b0;
        if (!w_ev_halt && !TRAP) begin
          if (w_ev_step) begin
            w_nxt         = S_STEP;
            w_bp_hit_n    = 1'b0;
            w_skip_n      = 1'b1;
            w_step_seen_n = 1'b0;
          end else if (w_ev_run) begin
            w_nxt      = S_RUN;
            w_bp_hit_n = 1'b0;
            w_skip_n   = 1'b1;
          end
        end
      end
      default: begin
        w_nxt = S_RUN;
      end
    endcase
    w_rdy_n = (w_nxt == S_RUN) || (w_nxt == S_STEP);
  end

  assign RDY    = r_rdy;
  assign HALTED = (r_state == S_HALT);
  assign BP_HIT = r_bp_hit;
  assign STATE  = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: one CPU bus cycle per table row, plus reset corner sequences.
// Latency: each row is 8 CLK (PHI2 low 4, high 4); outputs sampled on a CLK fall just before PHI2 falls.
// Backpressure: the table lists bus cycles as the CPU would present them, including RDY-low repeats.
module tb_cpu_run_ctrl;

  localparam logic [1:0] B_NO   = 2'd0;
  localparam logic [1:0] B_HALT = 2'd1;
  localparam logic [1:0] B_STEP = 2'd2;
  localparam logic [1:0] B_RUN  = 2'd3;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  typedef struct {
    logic [15:0] a;
    logic        s;
    logic        rw;
    logic        tr;
    logic        bpe;
    logic [1:0]  btn;
    logic        rdy;
    logic [1:0]  st;
    logic        bph;
  } vec_t;

  logic        CLK;
  logic        RES_;
  logic        PHI2;
  logic        SYNC;
  logic        RW_;
  logic [15:0] ABUS;
  logic        TRAP;
  logic        HALT_BTN_;
  logic        STEP_BTN_;
  logic        RUN_BTN_;
  logic        BP_EN;
  logic [15:0] BP_ADDR;
  logic        RDY;
  logic        HALTED;
  logic        BP_HIT;
  logic [1:0]  STATE;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vq[$];

  cpu_run_ctrl #(
    .SYSCLK_MHZ(27), .DEBOUNCE_MS(0), .WS_REGION(4'hA), .WS_CYCLES(2), .START_HALTED(1'b0)
  ) dut (
    .CLK(CLK), .RES_(RES_), .PHI2(PHI2), .SYNC(SYNC), .RW_(RW_), .ABUS(ABUS), .TRAP(TRAP),
    .HALT_BTN_(HALT_BTN_), .STEP_BTN_(STEP_BTN_), .RUN_BTN_(RUN_BTN_),
    .BP_EN(BP_EN), .BP_ADDR(BP_ADDR),
    .RDY(RDY), .HALTED(HALTED), .BP_HIT(BP_HIT), .STATE(STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(logic [15:0] a, logic s, logic rw, logic tr, logic bpe,
                              logic [1:0] btn, logic rdy, logic [1:0] st, logic bph);
    vec_t v;
    v.a = a; v.s = s; v.rw = rw; v.tr = tr; v.bpe = bpe; v.btn = btn;
    v.rdy = rdy; v.st = st; v.bph = bph;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One CPU cycle starting on a CLK fall: PHI2 low with the button held 3 CLK, then PHI2 high.
  task automatic cpu_cycle(input vec_t v);
    ABUS      = v.a;
    SYNC      = v.s;
    RW_       = v.rw;
    TRAP      = v.tr;
    BP_EN     = v.bpe;
    PHI2      = 1'b0;
    HALT_BTN_ = (v.btn != B_HALT);
    STEP_BTN_ = (v.btn != B_STEP);
    RUN_BTN_  = (v.btn != B_RUN);
    repeat (3) @(negedge CLK);
    HALT_BTN_ = 1'b1;
    STEP_BTN_ = 1'b1;
    RUN_BTN_  = 1'b1;
    @(negedge CLK);
    PHI2 = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic check_row(input string tag, input vec_t v);
    check({tag, " RDY"}, {15'd0, RDY}, {15'd0, v.rdy});
    check({tag, " STATE"}, {14'd0, STATE}, {14'd0, v.st});
    check({tag, " HALTED"}, {15'd0, HALTED}, {15'd0, (v.st == ST_HALT)});
    check({tag, " BP_HIT"}, {15'd0, BP_HIT}, {15'd0, v.bph});
  endtask

  // Assert reset mid-cycle, confirm reset values at once, then release with PHI2 low.
  task automatic pulse_reset(input string tag);
    RES_ = 1'b0;
    PHI2 = 1'b0;
    TRAP = 1'b0;
    #1;
    check({tag, " rst STATE"}, {14'd0, STATE}, {14'd0, ST_RUN});
    check({tag, " rst RDY"}, {15'd0, RDY}, 16'd1);
    check({tag, " rst HALTED"}, {15'd0, HALTED}, 16'd0);
    check({tag, " rst BP_HIT"}, {15'd0, BP_HIT}, 16'd0);
    repeat (2) @(negedge CLK);
    RES_ = 1'b1;
    @(negedge CLK);
    check({tag, " post-rst RDY"}, {15'd0, RDY}, 16'd1);
  endtask

  initial begin
    RES_ = 1'b0; PHI2 = 1'b0; SYNC = 1'b0; RW_ = 1'b1; ABUS = 16'h0000; TRAP = 1'b0;
    HALT_BTN_ = 1'b1; STEP_BTN_ = 1'b1; RUN_BTN_ = 1'b1; BP_EN = 1'b0; BP_ADDR = 16'hC010;

    // Halt request, single step, run
    vq.push_back(mk(16'hC000, 1'b1, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC001, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC001, 1'b1, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC002, 1'b0, 1'b1, 1'b0, 1'b0, B_HALT, 1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC002, 1'b1, 1'b1, 1'b0, 1'b0, B_NO,   1'b0, ST_HALT, 1'b0));
    vq.push_back(mk(16'hC002, 1'b1, 1'b1, 1'b0, 1'b0, B_NO,   1'b0, ST_HALT, 1'b0));
    vq.push_back(mk(16'hC002, 1'b1, 1'b1, 1'b0, 1'b0, B_STEP, 1'b1, ST_STEP, 1'b0));
    vq.push_back(mk(16'hC003, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_STEP, 1'b0));
    vq.push_back(mk(16'hC003, 1'b1, 1'b1, 1'b0, 1'b0, B_NO,   1'b0, ST_HALT, 1'b0));
    vq.push_back(mk(16'hC003, 1'b1, 1'b1, 1'b0, 1'b0, B_RUN,  1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC004, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    // Breakpoint at C010: hit, resume past it, hit again on the next visit
    vq.push_back(mk(16'hC00F, 1'b1, 1'b1, 1'b0, 1'b1, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC010, 1'b0, 1'b1, 1'b0, 1'b1, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC010, 1'b1, 1'b1, 1'b0, 1'b1, B_NO,   1'b0, ST_HALT, 1'b1));
    vq.push_back(mk(16'hC010, 1'b1, 1'b1, 1'b0, 1'b1, B_NO,   1'b0, ST_HALT, 1'b1));
    vq.push_back(mk(16'hC010, 1'b1, 1'b1, 1'b0, 1'b1, B_RUN,  1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC011, 1'b0, 1'b1, 1'b0, 1'b1, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC011, 1'b1, 1'b1, 1'b0, 1'b1, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC012, 1'b0, 1'b1, 1'b0, 1'b1, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC010, 1'b1, 1'b1, 1'b0, 1'b1, B_NO,   1'b0, ST_HALT, 1'b1));
    vq.push_back(mk(16'hC010, 1'b1, 1'b1, 1'b0, 1'b1, B_RUN,  1'b1, ST_RUN,  1'b0));
    // LDA $A000: two wait states, then STA $A000: none
    vq.push_back(mk(16'hC011, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC011, 1'b1, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC012, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC013, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hA000, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b0, ST_WAIT, 1'b0));
    vq.push_back(mk(16'hA000, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b0, ST_WAIT, 1'b0));
    vq.push_back(mk(16'hA000, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC014, 1'b1, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC015, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC016, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hA000, 1'b0, 1'b0, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    vq.push_back(mk(16'hC017, 1'b1, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));
    // TRAP in RUN, buttons ignored while TRAP is high
    vq.push_back(mk(16'hC018, 1'b0, 1'b1, 1'b1, 1'b0, B_NO,   1'b0, ST_HALT, 1'b0));
    vq.push_back(mk(16'hC018, 1'b0, 1'b1, 1'b1, 1'b0, B_STEP, 1'b0, ST_HALT, 1'b0));
    vq.push_back(mk(16'hC018, 1'b0, 1'b1, 1'b1, 1'b0, B_RUN,  1'b0, ST_HALT, 1'b0));
    vq.push_back(mk(16'hC018, 1'b0, 1'b1, 1'b0, 1'b0, B_RUN,  1'b1, ST_RUN,  1'b0));
    // TRAP mid-WAIT, then the same slow read restarts its wait states
    vq.push_back(mk(16'hA001, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b0, ST_WAIT, 1'b0));
    vq.push_back(mk(16'hA001, 1'b0, 1'b1, 1'b1, 1'b0, B_NO,   1'b0, ST_HALT, 1'b0));
    vq.push_back(mk(16'hA001, 1'b0, 1'b1, 1'b0, 1'b0, B_RUN,  1'b0, ST_WAIT, 1'b0));
    vq.push_back(mk(16'hA001, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b0, ST_WAIT, 1'b0));
    vq.push_back(mk(16'hA001, 1'b0, 1'b1, 1'b0, 1'b0, B_NO,   1'b1, ST_RUN,  1'b0));

    // Reset values while held, and one CLK after release
    repeat (3) @(negedge CLK);
    #1;
    check("reset STATE", {14'd0, STATE}, {14'd0, ST_RUN});
    check("reset RDY", {15'd0, RDY}, 16'd1);
    check("reset HALTED", {15'd0, HALTED}, 16'd0);
    check("reset BP_HIT", {15'd0, BP_HIT}, 16'd0);
    @(negedge CLK);
    RES_ = 1'b1;
    @(negedge CLK);
    check("post-reset RDY", {15'd0, RDY}, 16'd1);
    check("post-reset STATE", {14'd0, STATE}, {14'd0, ST_RUN});

    for (int i = 0; i < vq.size(); i++) begin
      cpu_cycle(vq[i]);
      check_row($sformatf("row%0d", i), vq[i]);
    end

    // Reset mid-WAIT
    begin
      vec_t v;
      v = mk(16'hA002, 1'b0, 1'b1, 1'b0, 1'b0, B_NO, 1'b0, ST_WAIT, 1'b0);
      cpu_cycle(v);
      check_row("wait-before-reset", v);
      pulse_reset("midwait");

      // Reset mid-STEP
      cpu_cycle(mk(16'hC100, 1'b0, 1'b1, 1'b0, 1'b0, B_HALT, 1'b1, ST_RUN, 1'b0));
      v = mk(16'hC101, 1'b1, 1'b1, 1'b0, 1'b0, B_NO, 1'b0, ST_HALT, 1'b0);
      cpu_cycle(v);
      check_row("halt-before-step", v);
      v = mk(16'hC101, 1'b1, 1'b1, 1'b0, 1'b0, B_STEP, 1'b1, ST_STEP, 1'b0);
      cpu_cycle(v);
      check_row("step-before-reset", v);
      pulse_reset("midstep");

      // Breakpoint flag does not survive reset
      v = mk(16'hC010, 1'b1, 1'b1, 1'b0, 1'b1, B_NO, 1'b0, ST_HALT, 1'b1);
      cpu_cycle(v);
      check_row("bp-before-reset", v);
      pulse_reset("bphit");

      // A pending halt request does not survive reset
      cpu_cycle(mk(16'hC200, 1'b0, 1'b1, 1'b0, 1'b0, B_HALT, 1'b1, ST_RUN, 1'b0));
      pulse_reset("pending");
      v = mk(16'hC201, 1'b1, 1'b1, 1'b0, 1'b0, B_NO, 1'b1, ST_RUN, 1'b0);
      cpu_cycle(v);
      check_row("no-pending-halt", v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
